// File: rtl/life_step_engine.sv
// Conway's Life (B3/S23) generation stepper over a double-banked toroidal 1-bit cell RAM,
// mirroring every new cell to VRAM. Define LIFE_SEED_EN to enable the random seed-fill mode.
module life_step_engine #(
  parameter int unsigned GRID_W    = 160,
  parameter int unsigned GRID_H    = 120,
  parameter int unsigned BANK_SIZE = GRID_W * GRID_H
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_i,
  input  logic        seed_i,
  input  logic        seed_bit_i,
  output logic [19:0] rd_addr_o,
  input  logic        rd_data_i,
  output logic [19:0] wr_addr_o,
  output logic        wr_data_o,
  output logic        wr_en_o,
  output logic [19:0] vram_addr_o,
  output logic        vram_wdata_o,
  output logic        vram_we_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        bank_o
);

  localparam logic [7:0] XMax = 8'(GRID_W - 1);
  localparam logic [6:0] YMax = 7'(GRID_H - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StWrite,
    StSeed,
    StFinish
  } state_e;

  state_e      state_q;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [3:0]  k_q;
  logic [3:0]  count_q;
  logic        centre_q;
  logic        bank_q;
  logic [19:0] rd_addr_q;
  logic [19:0] wr_addr_q;
  logic        wr_data_q;
  logic        wr_en_q;
  logic [19:0] vram_addr_q;
  logic        busy_q;
  logic        done_q;

  logic [3:0]  count_total;
  logic        last_cell;
  logic [7:0]  x_nxt;
  logic [6:0]  y_nxt;

`ifndef LIFE_SEED_EN
  logic unused_seed;
  assign unused_seed = seed_i ^ seed_bit_i;
`endif

  function automatic logic [19:0] cell_idx(input logic [7:0] cx, input logic [6:0] cy);
    return 20'(cy) * 20'(GRID_W) + 20'(cx);
  endfunction

  function automatic logic [19:0] bank_base(input logic b);
    return b ? 20'(BANK_SIZE) : 20'd0;
  endfunction

  // Address of neighbour kk (row-major over dy,dx in -1..1) around (cx,cy) with torus wrap.
  function automatic logic [19:0] nbr_addr(input logic [7:0] cx, input logic [6:0] cy,
                                           input logic [3:0] kk, input logic b);
    logic [7:0] nx;
    logic [6:0] ny;
    if (kk < 4'd3)      ny = (cy == 7'd0) ? YMax : cy - 7'd1;
    else if (kk < 4'd6) ny = cy;
    else                ny = (cy == YMax) ? 7'd0 : cy + 7'd1;
    case (kk)
      4'd0, 4'd3, 4'd6: nx = (cx == 8'd0) ? XMax : cx - 8'd1;
      4'd2, 4'd5, 4'd8: nx = (cx == XMax) ? 8'd0 : cx + 8'd1;
      default:          nx = cx;
    endcase
    return bank_base(b) + cell_idx(nx, ny);
  endfunction

  always_comb begin
    count_total = count_q + {3'b000, rd_data_i};
    last_cell   = (x_q == XMax) && (y_q == YMax);
    if (x_q == XMax) begin
      x_nxt = 8'd0;
      y_nxt = y_q + 7'd1;
    end else begin
      x_nxt = x_q + 8'd1;
      y_nxt = y_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= 8'd0;
      y_q         <= 7'd0;
      k_q         <= 4'd0;
      count_q     <= 4'd0;
      centre_q    <= 1'b0;
      bank_q      <= 1'b0;
      rd_addr_q   <= 20'd0;
      wr_addr_q   <= 20'd0;
      wr_data_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      vram_addr_q <= 20'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          wr_en_q <= 1'b0;
`ifdef LIFE_SEED_EN
          if (seed_i) begin
            state_q     <= StSeed;
            busy_q      <= 1'b1;
            x_q         <= 8'd0;
            y_q         <= 7'd0;
            wr_en_q     <= 1'b1;
            wr_data_q   <= seed_bit_i;
            wr_addr_q   <= bank_base(bank_q);
            vram_addr_q <= 20'd0;
          end else
`endif
          if (step_i) begin
            state_q   <= StFetch;
            busy_q    <= 1'b1;
            x_q       <= 8'd0;
            y_q       <= 7'd0;
            k_q       <= 4'd0;
            count_q   <= 4'd0;
            centre_q  <= 1'b0;
            rd_addr_q <= nbr_addr(8'd0, 7'd0, 4'd0, bank_q);
          end
        end
        StFetch: begin
          // Data returning now belongs to the read issued for k-1.
          if (k_q != 4'd0) begin
            if (k_q == 4'd5) centre_q <= rd_data_i;
            else             count_q  <= count_total;
          end
          if (k_q == 4'd8) begin
            state_q <= StDrain;
            k_q     <= 4'd0;
          end else begin
            k_q       <= k_q + 4'd1;
            rd_addr_q <= nbr_addr(x_q, y_q, k_q + 4'd1, bank_q);
          end
        end
        StDrain: begin
          state_q     <= StWrite;
          wr_data_q   <= (count_total == 4'd3) || (centre_q && (count_total == 4'd2));
          wr_en_q     <= 1'b1;
          wr_addr_q   <= bank_base(~bank_q) + cell_idx(x_q, y_q);
          vram_addr_q <= cell_idx(x_q, y_q);
        end
        StWrite: begin
          wr_en_q  <= 1'b0;
          count_q  <= 4'd0;
          centre_q <= 1'b0;
          if (last_cell) begin
            state_q <= StFinish;
            done_q  <= 1'b1;
            bank_q  <= ~bank_q;
          end else begin
            state_q   <= StFetch;
            x_q       <= x_nxt;
            y_q       <= y_nxt;
            rd_addr_q <= nbr_addr(x_nxt, y_nxt, 4'd0, bank_q);
          end
        end
`ifdef LIFE_SEED_EN
        StSeed: begin
          if (last_cell) begin
            state_q <= StFinish;
            done_q  <= 1'b1;
            wr_en_q <= 1'b0;
          end else begin
            x_q         <= x_nxt;
            y_q         <= y_nxt;
            wr_data_q   <= seed_bit_i;
            wr_addr_q   <= bank_base(bank_q) + cell_idx(x_nxt, y_nxt);
            vram_addr_q <= cell_idx(x_nxt, y_nxt);
          end
        end
`endif
        StFinish: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_addr_o    = rd_addr_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign wr_en_o      = wr_en_q;
  assign vram_addr_o  = vram_addr_q;
  assign vram_wdata_o = wr_data_q;
  assign vram_we_o    = wr_en_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign bank_o       = bank_q;

endmodule

// File: tb/tb_life_step_engine.sv
// Bench for life_step_engine on a reduced 20x12 torus, with a cell-RAM/VRAM model and a
// plain neighbour-count Life reference.
module tb_life_step_engine;

  localparam int W         = 20;
  localparam int H         = 12;
  localparam int N         = W * H;
  localparam int MemDepth  = 1 << 20;
  localparam int GenLimit  = N * 11 + 50;

  logic        clk;
  logic        rst_n;
  logic        step;
  logic        seed;
  logic        seed_bit;
  logic [19:0] rd_addr;
  logic        rd_data;
  logic [19:0] wr_addr;
  logic        wr_data;
  logic        wr_en;
  logic [19:0] vram_addr;
  logic        vram_wdata;
  logic        vram_we;
  logic        busy;
  logic        done;
  logic        bank;

  logic        mem      [0:MemDepth-1];
  logic        vram     [0:MemDepth-1];
  logic        init_mem [0:2*N-1];
  logic        tb_load;

  bit          cur [0:N-1];
  bit          nxt [0:N-1];
  int          exp_bank;
  int          n_checks;
  int          n_fail;

  life_step_engine #(
    .GRID_W   (W),
    .GRID_H   (H),
    .BANK_SIZE(N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .step_i      (step),
    .seed_i      (seed),
    .seed_bit_i  (seed_bit),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .wr_en_o     (wr_en),
    .vram_addr_o (vram_addr),
    .vram_wdata_o(vram_wdata),
    .vram_we_o   (vram_we),
    .busy_o      (busy),
    .done_o      (done),
    .bank_o      (bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous 1-cycle-latency cell RAM plus VRAM, with a bulk preload port.
  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 2 * N; i++) mem[i] <= init_mem[i];
      for (int i = 0; i < N; i++) vram[i] <= 1'b0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (vram_we) vram[vram_addr] <= vram_wdata;
    end
    rd_data <= mem[rd_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void compute_ref();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int cnt = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0) cnt += int'(cur[((y + dy + H) % H) * W + (x + dx + W) % W]);
        nxt[y * W + x] = (cnt == 3) || (cur[y * W + x] && cnt == 2);
      end
    end
  endfunction

  function automatic void clear_grids();
    for (int i = 0; i < N; i++) begin
      cur[i] = 1'b0;
      nxt[i] = 1'b0;
    end
  endfunction

  function automatic int count_bank_err(input int base);
    int e = 0;
    for (int i = 0; i < N; i++) if (mem[20'(base + i)] !== nxt[i]) e++;
    return e;
  endfunction

  function automatic int count_vram_err();
    int e = 0;
    for (int i = 0; i < N; i++) if (vram[20'(i)] !== nxt[i]) e++;
    return e;
  endfunction

  // Place cur into the current bank; fill the other bank with junk that must be overwritten.
  task automatic load_grid();
    for (int i = 0; i < N; i++) begin
      init_mem[exp_bank * N + i]       = cur[i];
      init_mem[(1 - exp_bank) * N + i] = 1'($urandom_range(0, 1));
    end
    tb_load = 1'b1;
    tick();
    tb_load = 1'b0;
  endtask

  task automatic run_gen(input bit use_seed, input int poke_at, input int wbase,
                         output int busy_cyc, output int writes, output int dones,
                         output int first_wr, output int addr_err);
    busy_cyc = 0;
    writes   = 0;
    dones    = 0;
    first_wr = -1;
    addr_err = 0;
    if (use_seed) seed = 1'b1;
    else          step = 1'b1;
    tick();
    step = 1'b0;
    seed = 1'b0;
    for (int cyc = 1; cyc <= GenLimit; cyc++) begin
      step = (cyc == poke_at);
      if (!busy) break;
      busy_cyc++;
      if (done) dones++;
      if (wr_en) begin
        writes++;
        if (first_wr < 0) first_wr = cyc;
        if (vram_we !== 1'b1 || vram_wdata !== wr_data ||
            wr_addr !== 20'(wbase) + vram_addr) addr_err++;
      end else if (vram_we !== 1'b0) begin
        addr_err++;
      end
      tick();
    end
    step = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (rd_addr !== 20'd0) begin n_fail++; $display("FAIL reset_rd_addr got %0h want 0", rd_addr); end
    n_checks++; if (wr_addr !== 20'd0) begin n_fail++; $display("FAIL reset_wr_addr got %0h want 0", wr_addr); end
    n_checks++; if (vram_addr !== 20'd0) begin n_fail++; $display("FAIL reset_vram_addr got %0h want 0", vram_addr); end
    n_checks++;
    if ({wr_data, wr_en, vram_wdata, vram_we} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes got %b want 0000", {wr_data, wr_en, vram_wdata, vram_we});
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (bank !== 1'b0) begin n_fail++; $display("FAIL reset_bank got %b want 0", bank); end
    rst_n = 1'b1;
    tick();
    exp_bank = 0;
  endtask

  task automatic test_blinker();
    int bc, wr, dn, fw, ae, old;
    clear_grids();
    cur[10 * W + 10] = 1'b1; cur[10 * W + 11] = 1'b1; cur[10 * W + 12] = 1'b1;
    nxt[9 * W + 11]  = 1'b1; nxt[10 * W + 11] = 1'b1; nxt[11 * W + 11] = 1'b1;
    load_grid();
    old = exp_bank;
    run_gen(1'b0, 0, (1 - old) * N, bc, wr, dn, fw, ae);
    exp_bank = 1 - old;
    n_checks++; if (count_bank_err((1 - old) * N) != 0) begin n_fail++; $display("FAIL blinker_bank cells wrong %0d want 0", count_bank_err((1 - old) * N)); end
    n_checks++; if (count_vram_err() != 0) begin n_fail++; $display("FAIL blinker_vram cells wrong %0d want 0", count_vram_err()); end
    n_checks++; if (dn != 1) begin n_fail++; $display("FAIL blinker_done pulses %0d want 1", dn); end
    n_checks++; if (bc != N * 11 + 1) begin n_fail++; $display("FAIL blinker_busy cycles %0d want %0d", bc, N * 11 + 1); end
    n_checks++; if (wr != N) begin n_fail++; $display("FAIL blinker_writes %0d want %0d", wr, N); end
    n_checks++; if (fw != 11) begin n_fail++; $display("FAIL blinker_first_write cycle %0d want 11", fw); end
    n_checks++; if (ae != 0) begin n_fail++; $display("FAIL blinker_strobe_addr errors %0d want 0", ae); end
    n_checks++; if (bank !== 1'(exp_bank)) begin n_fail++; $display("FAIL blinker_bank_out got %b want %0d", bank, exp_bank); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL blinker_idle busy got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    int bc, wr, dn, fw, ae, old;
    clear_grids();
    cur[W - 1] = 1'b1; cur[0] = 1'b1; cur[1] = 1'b1;
    nxt[(H - 1) * W] = 1'b1; nxt[0] = 1'b1; nxt[W] = 1'b1;
    load_grid();
    old = exp_bank;
    run_gen(1'b0, 0, (1 - old) * N, bc, wr, dn, fw, ae);
    exp_bank = 1 - old;
    n_checks++; if (count_bank_err((1 - old) * N) != 0) begin n_fail++; $display("FAIL wrap_bank cells wrong %0d want 0", count_bank_err((1 - old) * N)); end
    n_checks++; if (count_vram_err() != 0) begin n_fail++; $display("FAIL wrap_vram cells wrong %0d want 0", count_vram_err()); end
    n_checks++; if (bank !== 1'(exp_bank)) begin n_fail++; $display("FAIL wrap_bank_out got %b want %0d", bank, exp_bank); end
  endtask

  task automatic test_random_gens();
    int bc, wr, dn, fw, ae, old;
    clear_grids();
    for (int i = 0; i < N; i++) cur[i] = ($urandom_range(0, 2) == 0);
    load_grid();
    for (int g = 0; g < 2; g++) begin
      if (g != 0) for (int i = 0; i < N; i++) cur[i] = nxt[i];
      compute_ref();
      old = exp_bank;
      run_gen(1'b0, 0, (1 - old) * N, bc, wr, dn, fw, ae);
      exp_bank = 1 - old;
      n_checks++; if (count_bank_err((1 - old) * N) != 0) begin n_fail++; $display("FAIL random_gen%0d_bank cells wrong %0d want 0", g, count_bank_err((1 - old) * N)); end
      n_checks++; if (count_vram_err() != 0) begin n_fail++; $display("FAIL random_gen%0d_vram cells wrong %0d want 0", g, count_vram_err()); end
      n_checks++; if (bank !== 1'(exp_bank)) begin n_fail++; $display("FAIL random_gen%0d_bank_out got %b want %0d", g, bank, exp_bank); end
      n_checks++; if (ae != 0 || dn != 1) begin n_fail++; $display("FAIL random_gen%0d_strobes addr_err %0d done %0d want 0 and 1", g, ae, dn); end
    end
  endtask

  task automatic test_busy_ignore();
    int bc, wr, dn, fw, ae, old;
    clear_grids();
    for (int i = 0; i < N; i++) cur[i] = ($urandom_range(0, 1) == 0);
    compute_ref();
    load_grid();
    old = exp_bank;
    run_gen(1'b0, 1000, (1 - old) * N, bc, wr, dn, fw, ae);
    exp_bank = 1 - old;
    n_checks++; if (dn != 1) begin n_fail++; $display("FAIL busy_ignore_done pulses %0d want 1", dn); end
    n_checks++; if (bc != N * 11 + 1) begin n_fail++; $display("FAIL busy_ignore_cycles %0d want %0d", bc, N * 11 + 1); end
    n_checks++; if (count_bank_err((1 - old) * N) != 0) begin n_fail++; $display("FAIL busy_ignore_bank cells wrong %0d want 0", count_bank_err((1 - old) * N)); end
    repeat (5) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_no_restart busy %b want 0", busy); end
  endtask

`ifdef LIFE_SEED_EN
  task automatic test_seed();
    int bc, wr, dn, fw, ae, old;
    clear_grids();
    for (int i = 0; i < N; i++) nxt[i] = 1'b1;
    load_grid();
    seed_bit = 1'b1;
    old = exp_bank;
    run_gen(1'b1, 0, old * N, bc, wr, dn, fw, ae);
    n_checks++; if (bc != N + 1) begin n_fail++; $display("FAIL seed_busy cycles %0d want %0d", bc, N + 1); end
    n_checks++; if (wr != N || ae != 0) begin n_fail++; $display("FAIL seed_writes %0d addr_err %0d want %0d and 0", wr, ae, N); end
    n_checks++; if (bank !== 1'(old)) begin n_fail++; $display("FAIL seed_bank_out got %b want %0d", bank, old); end
    n_checks++; if (count_bank_err(old * N) != 0) begin n_fail++; $display("FAIL seed_fill cells wrong %0d want 0", count_bank_err(old * N)); end
    n_checks++; if (count_vram_err() != 0) begin n_fail++; $display("FAIL seed_vram cells wrong %0d want 0", count_vram_err()); end
    for (int i = 0; i < N; i++) cur[i] = 1'b1;
    compute_ref();
    run_gen(1'b0, 0, (1 - old) * N, bc, wr, dn, fw, ae);
    exp_bank = 1 - old;
    n_checks++; if (count_bank_err((1 - old) * N) != 0) begin n_fail++; $display("FAIL seed_step_all_dead cells wrong %0d want 0", count_bank_err((1 - old) * N)); end
  endtask
`else
  task automatic test_seed();
    int busy_seen, wr_seen;
    busy_seen = 0;
    wr_seen   = 0;
    seed_bit  = 1'b1;
    seed      = 1'b1;
    tick();
    seed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_seen++;
      if (wr_en || vram_we) wr_seen++;
      tick();
    end
    n_checks++; if (busy_seen != 0) begin n_fail++; $display("FAIL seed_ignored busy cycles %0d want 0", busy_seen); end
    n_checks++; if (wr_seen != 0) begin n_fail++; $display("FAIL seed_ignored write cycles %0d want 0", wr_seen); end
    n_checks++; if (bank !== 1'(exp_bank)) begin n_fail++; $display("FAIL seed_ignored bank got %b want %0d", bank, exp_bank); end
  endtask
`endif

  task automatic test_reset_mid();
    int bc, wr, dn, fw, ae, writes, hit;
    clear_grids();
    if (exp_bank == 0) begin
      load_grid();
      run_gen(1'b0, 0, N, bc, wr, dn, fw, ae);
      exp_bank = 1;
    end
    for (int i = 0; i < N; i++) cur[i] = ($urandom_range(0, 2) == 0);
    load_grid();
    writes = 0;
    hit    = 0;
    step   = 1'b1;
    tick();
    step = 1'b0;
    for (int cyc = 0; cyc < GenLimit && hit == 0; cyc++) begin
      if (wr_en) begin
        writes++;
        if (writes == 50) hit = 1;
      end
      if (hit == 0) tick();
    end
    n_checks++; if (hit != 1) begin n_fail++; $display("FAIL reset_mid_reach writes %0d want 50", writes); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({wr_en, vram_we} !== 2'b00) begin n_fail++; $display("FAIL reset_mid_strobes got %b want 00", {wr_en, vram_we}); end
    n_checks++; if (bank !== 1'b0) begin n_fail++; $display("FAIL reset_mid_bank got %b want 0", bank); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got %b want 0", busy); end
    tick();
    rst_n = 1'b1;
    tick();
    exp_bank = 0;
    compute_ref();
    load_grid();
    run_gen(1'b0, 0, N, bc, wr, dn, fw, ae);
    exp_bank = 1;
    n_checks++; if (bc != N * 11 + 1 || dn != 1) begin n_fail++; $display("FAIL reset_mid_restart busy %0d done %0d want %0d and 1", bc, dn, N * 11 + 1); end
    n_checks++; if (count_bank_err(N) != 0) begin n_fail++; $display("FAIL reset_mid_result cells wrong %0d want 0", count_bank_err(N)); end
    n_checks++; if (bank !== 1'b1) begin n_fail++; $display("FAIL reset_mid_bank_after got %b want 1", bank); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_bank = 0;
    rst_n    = 1'b0;
    step     = 1'b0;
    seed     = 1'b0;
    seed_bit = 1'b0;
    tb_load  = 1'b0;
    test_reset();
    test_blinker();
    test_wrap();
    test_random_gens();
    test_busy_ignore();
    test_seed();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
